te_block_packer: RTL and testbench

Multi-port successor to the single-port trace block FSM. It accepts up to NRET committed instructions per cycle plus one trap event and groups them into instruction blocks. Each block carries the start address, the retired length in halfwords, the last-instruction size and the block type. Closed blocks are queued in a DEPTH-entry output FIFO with a valid/ready handshake toward the trace encoder packetiser.

---
 rtl/te_block_packer.sv | 194 +++++++++++++++++++
 tb/tb_te_block_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_block_packer.sv
// Multi-port trace instruction block packer with output FIFO.
// Optional: define TE_IRETIRE_SPLIT_EN to close long blocks before iretire overflows.
module te_block_packer #(
    parameter int unsigned NRET        = 2,
    parameter int unsigned XLEN        = 64,
    parameter int unsigned IRETIRE_LEN = 32,
    parameter int unsigned ITYPE_LEN   = 3,
    parameter int unsigned CAUSE_LEN   = 5,
    parameter int unsigned PRIV_LEN    = 2,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NRET-1:0]             uop_valid_i,
    input  logic [NRET*ITYPE_LEN-1:0]   uop_itype_i,
    input  logic [NRET*XLEN-1:0]        uop_pc_i,
    input  logic [NRET-1:0]             uop_compressed_i,
    input  logic [PRIV_LEN-1:0]         priv_i,
    input  logic                        trap_valid_i,
    input  logic                        trap_interrupt_i,
    input  logic [CAUSE_LEN-1:0]        cause_i,
    input  logic [XLEN-1:0]             tval_i,
    input  logic                        ready_i,
    output logic                        valid_o,
    output logic [IRETIRE_LEN-1:0]      iretire_o,
    output logic                        ilastsize_o,
    output logic [ITYPE_LEN-1:0]        itype_o,
    output logic [CAUSE_LEN-1:0]        cause_o,
    output logic [XLEN-1:0]             tval_o,
    output logic [PRIV_LEN-1:0]         priv_o,
    output logic [XLEN-1:0]             iaddr_o,
    output logic                        overflow_o
);

    localparam int unsigned CW = IRETIRE_LEN + 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] SAT = CW'({IRETIRE_LEN{1'b1}});
`ifdef TE_IRETIRE_SPLIT_EN
    localparam logic [CW-1:0] SPLIT_TH = SAT - CW'(2 * NRET - 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [XLEN-1:0]        tval;
        logic [IRETIRE_LEN-1:0] iretire;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [PRIV_LEN-1:0]    priv;
        logic                   ilastsize;
    } entry_t;

    function automatic logic [IRETIRE_LEN-1:0] sat_f(input logic [CW-1:0] v);
        return (v > SAT) ? SAT[IRETIRE_LEN-1:0] : v[IRETIRE_LEN-1:0];
    endfunction

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;
    logic [IRETIRE_LEN-1:0] iretire_q, iretire_d;

    logic                   open;
    logic [XLEN-1:0]        addr;
    logic [CW-1:0]          cnt;
    logic                   last;
    logic                   push;
    entry_t                 entry;
    logic [ITYPE_LEN-1:0]   it_k;
    logic [XLEN-1:0]        pc_k;

    always_comb begin
        push  = 1'b0;
        entry = '0;
        it_k  = '0;
        pc_k  = '0;
        last  = 1'b0;
        open  = (state_q == COUNT);
        addr  = iaddr_q;
        cnt   = {1'b0, iretire_q};
        for (int k = 0; k < NRET; k++) begin
            if (uop_valid_i[k]) begin
                it_k = uop_itype_i[k*ITYPE_LEN +: ITYPE_LEN];
                pc_k = uop_pc_i[k*XLEN +: XLEN];
                last = !uop_compressed_i[k];
                if (!open) begin
                    addr = pc_k;
                    cnt  = '0;
                end
                cnt = cnt + (uop_compressed_i[k] ? CW'(1) : CW'(2));
                if (it_k == '0) begin
                    open = 1'b1;
                end else begin
                    push            = 1'b1;
                    entry.iaddr     = addr;
                    entry.iretire   = sat_f(cnt);
                    entry.itype     = it_k;
                    entry.ilastsize = last;
                    entry.priv      = priv_i;
                    open            = 1'b0;
                    addr            = '0;
                    cnt             = '0;
                end
            end
        end
        if (trap_valid_i) begin
            push            = 1'b1;
            entry.iaddr     = open ? addr : '0;
            entry.iretire   = open ? sat_f(cnt) : '0;
            entry.itype     = trap_interrupt_i ? ITYPE_LEN'(2) : ITYPE_LEN'(1);
            entry.cause     = cause_i;
            entry.tval      = trap_interrupt_i ? '0 : tval_i;
            entry.ilastsize = last;
            entry.priv      = priv_i;
            open            = 1'b0;
            addr            = '0;
            cnt             = '0;
`ifdef TE_IRETIRE_SPLIT_EN
        end else if (!push && open && cnt >= SPLIT_TH) begin
            // split early so the next cycle's worst case cannot overflow
            push            = 1'b1;
            entry.iaddr     = addr;
            entry.iretire   = sat_f(cnt);
            entry.itype     = '0;
            entry.ilastsize = last;
            entry.priv      = priv_i;
            open            = 1'b0;
            addr            = '0;
            cnt             = '0;
`endif
        end
        state_d   = open ? COUNT : IDLE;
        iaddr_d   = addr;
        iretire_d = sat_f(cnt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            iaddr_q   <= '0;
            iretire_q <= '0;
        end else begin
            state_q   <= state_d;
            iaddr_q   <= iaddr_d;
            iretire_q <= iretire_d;
        end
    end

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   fill_q, fill_d;
    logic          overflow_q, overflow_d;
    logic          pop, full, wr_en;

    always_comb begin
        pop        = (fill_q != '0) && ready_i;
        full       = (fill_q == (AW+1)'(DEPTH));
        wr_en      = push && (!full || pop);
        wr_d       = wr_q + AW'(wr_en);
        rd_d       = rd_q + AW'(pop);
        fill_d     = fill_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        overflow_d = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q       <= '0;
            rd_q       <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            if (wr_en) mem_q[wr_q] <= entry;
        end
    end

    assign valid_o     = (fill_q != '0);
    assign iretire_o   = mem_q[rd_q].iretire;
    assign ilastsize_o = mem_q[rd_q].ilastsize;
    assign itype_o     = mem_q[rd_q].itype;
    assign cause_o     = mem_q[rd_q].cause;
    assign tval_o      = mem_q[rd_q].tval;
    assign priv_o      = mem_q[rd_q].priv;
    assign iaddr_o     = mem_q[rd_q].iaddr;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_te_block_packer.sv
// Directed self-checking bench for te_block_packer.
// Split behaviour is checked against TE_IRETIRE_SPLIT_EN as compiled.
module tb_te_block_packer;

    logic         clk;
    logic         rst_n;
    logic [1:0]   uop_valid;
    logic [5:0]   uop_itype;
    logic [127:0] uop_pc;
    logic [1:0]   uop_comp;
    logic [1:0]   priv;
    logic         trap_valid;
    logic         trap_int;
    logic [4:0]   cause;
    logic [63:0]  tval;
    logic         ready;

    logic         valid_o;
    logic [31:0]  iretire_o;
    logic         ilastsize_o;
    logic [2:0]   itype_o;
    logic [4:0]   cause_o;
    logic [63:0]  tval_o;
    logic [1:0]   priv_o;
    logic [63:0]  iaddr_o;
    logic         overflow_o;

    logic         s_valid;
    logic [3:0]   s_iretire;
    logic         s_ilast;
    logic [2:0]   s_itype;
    logic [4:0]   s_cause;
    logic [63:0]  s_tval;
    logic [1:0]   s_priv;
    logic [63:0]  s_iaddr;
    logic         s_overflow;
    logic         s_ready;

    int total;
    int bad;

    logic [171:0] head;
    logic [72:0]  s_head;
    assign head   = {valid_o, priv_o, itype_o, cause_o, ilastsize_o,
                     iretire_o, iaddr_o, tval_o};
    assign s_head = {s_valid, s_itype, s_ilast, s_iretire, s_iaddr};

    te_block_packer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .uop_valid_i(uop_valid), .uop_itype_i(uop_itype),
        .uop_pc_i(uop_pc), .uop_compressed_i(uop_comp),
        .priv_i(priv), .trap_valid_i(trap_valid),
        .trap_interrupt_i(trap_int), .cause_i(cause), .tval_i(tval),
        .ready_i(ready), .valid_o(valid_o), .iretire_o(iretire_o),
        .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o),
        .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
        .overflow_o(overflow_o)
    );

    te_block_packer #(.IRETIRE_LEN(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n),
        .uop_valid_i(uop_valid), .uop_itype_i(uop_itype),
        .uop_pc_i(uop_pc), .uop_compressed_i(uop_comp),
        .priv_i(priv), .trap_valid_i(trap_valid),
        .trap_interrupt_i(trap_int), .cause_i(cause), .tval_i(tval),
        .ready_i(s_ready), .valid_o(s_valid), .iretire_o(s_iretire),
        .ilastsize_o(s_ilast), .itype_o(s_itype), .cause_o(s_cause),
        .tval_o(s_tval), .priv_o(s_priv), .iaddr_o(s_iaddr),
        .overflow_o(s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        uop_valid  = '0;
        uop_itype  = '0;
        uop_pc     = '0;
        uop_comp   = '0;
        trap_valid = 1'b0;
        trap_int   = 1'b0;
        cause      = '0;
        tval       = '0;
    endtask

    task automatic set_port(input int k, input logic [2:0] it,
                            input logic [63:0] pc, input logic c);
        uop_valid[k]         = 1'b1;
        uop_itype[k*3 +: 3]  = it;
        uop_pc[k*64 +: 64]   = pc;
        uop_comp[k]          = c;
    endtask

    task automatic test_reset();
        logic [172:0] exp0;
        exp0 = '0;
        rst_n = 1'b0;
        clear_in();
        priv    = 2'd3;
        ready   = 1'b0;
        s_ready = 1'b1;
        #2;
        total++;
        if ({head, overflow_o} !== exp0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", {head, overflow_o}, exp0);
        end
        #20 rst_n = 1'b1;
        tick();
        total++;
        if ({head, overflow_o} !== exp0) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", {head, overflow_o}, exp0);
        end
    endtask

    task automatic test_basic();
        logic [171:0] e;
        set_port(0, 3'd0, 64'h1000, 1'b0);
        tick();
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_open_no_entry got=%b exp=0", valid_o);
        end
        clear_in();
        set_port(0, 3'd0, 64'h1004, 1'b1);
        set_port(1, 3'd4, 64'h1006, 1'b0);
        tick();
        clear_in();
        e = {1'b1, 2'd3, 3'd4, 5'd0, 1'b1, 32'd5, 64'h1000, 64'h0};
        total++;
        if (head !== e) begin
            bad++;
            $display("FAIL basic_entry got=%h exp=%h", head, e);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_pop got=%b exp=0", valid_o);
        end
    endtask

    task automatic test_special_trap();
        logic [171:0] e;
        set_port(0, 3'd3, 64'h2000, 1'b1);
        set_port(1, 3'd0, 64'h2002, 1'b0);
        tick();
        clear_in();
        e = {1'b1, 2'd3, 3'd3, 5'd0, 1'b0, 32'd1, 64'h2000, 64'h0};
        total++;
        if (head !== e) begin
            bad++;
            $display("FAIL special_first got=%h exp=%h", head, e);
        end
        trap_valid = 1'b1;
        cause      = 5'd2;
        tval       = 64'hBAD;
        tick();
        clear_in();
        ready = 1'b1;
        tick();
        e = {1'b1, 2'd3, 3'd1, 5'd2, 1'b0, 32'd2, 64'h2002, 64'hBAD};
        total++;
        if (head !== e) begin
            bad++;
            $display("FAIL trap_entry got=%h exp=%h", head, e);
        end
        tick();
        ready = 1'b0;
        total++;
        if (valid_o !== 1'b0) begin
            bad++;
            $display("FAIL trap_drain got=%b exp=0", valid_o);
        end
    endtask

    task automatic test_interrupt();
        logic [171:0] e;
        trap_valid = 1'b1;
        trap_int   = 1'b1;
        cause      = 5'd7;
        tval       = 64'h55;
        tick();
        clear_in();
        e = {1'b1, 2'd3, 3'd2, 5'd7, 1'b0, 32'd0, 64'h0, 64'h0};
        total++;
        if (head !== e) begin
            bad++;
            $display("FAIL interrupt_entry got=%h exp=%h", head, e);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [171:0] e1;
        logic [171:0] e2;
        e1 = {1'b1, 2'd3, 3'd3, 5'd0, 1'b1, 32'd2, 64'h4000, 64'h0};
        e2 = {1'b1, 2'd3, 3'd4, 5'd0, 1'b0, 32'd1, 64'h4010, 64'h0};
        ready = 1'b0;
        set_port(0, 3'd3, 64'h4000, 1'b0);
        tick();
        clear_in();
        total++;
        if ({head, overflow_o} !== {e1, 1'b0}) begin
            bad++;
            $display("FAIL ovf_first got=%h exp=%h", {head, overflow_o}, {e1, 1'b0});
        end
        set_port(0, 3'd4, 64'h4010, 1'b1);
        tick();
        clear_in();
        total++;
        if ({head, overflow_o} !== {e1, 1'b0}) begin
            bad++;
            $display("FAIL ovf_full got=%h exp=%h", {head, overflow_o}, {e1, 1'b0});
        end
        set_port(0, 3'd5, 64'h4020, 1'b0);
        tick();
        clear_in();
        total++;
        if ({head, overflow_o} !== {e1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_drop got=%h exp=%h", {head, overflow_o}, {e1, 1'b1});
        end
        tick();
        total++;
        if (head !== e1) begin
            bad++;
            $display("FAIL ovf_stable got=%h exp=%h", head, e1);
        end
        ready = 1'b1;
        tick();
        total++;
        if (head !== e2) begin
            bad++;
            $display("FAIL ovf_drain2 got=%h exp=%h", head, e2);
        end
        tick();
        total++;
        if ({valid_o, overflow_o} !== 2'b01) begin
            bad++;
            $display("FAIL ovf_empty_sticky got=%b exp=01", {valid_o, overflow_o});
        end
        ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [171:0] e;
        logic [172:0] exp0;
        exp0 = '0;
        set_port(0, 3'd3, 64'h5000, 1'b0);
        tick();
        clear_in();
        set_port(0, 3'd3, 64'h5002, 1'b0);
        set_port(1, 3'd0, 64'h5004, 1'b0);
        tick();
        clear_in();
        total++;
        if (valid_o !== 1'b1) begin
            bad++;
            $display("FAIL mrst_prefill got=%b exp=1", valid_o);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({head, overflow_o} !== exp0) begin
            bad++;
            $display("FAIL mrst_async got=%h exp=%h", {head, overflow_o}, exp0);
        end
        #3 rst_n = 1'b1;
        tick();
        set_port(0, 3'd6, 64'h3000, 1'b1);
        tick();
        clear_in();
        e = {1'b1, 2'd3, 3'd6, 5'd0, 1'b0, 32'd1, 64'h3000, 64'h0};
        total++;
        if ({head, overflow_o} !== {e, 1'b0}) begin
            bad++;
            $display("FAIL mrst_first got=%h exp=%h", {head, overflow_o}, {e, 1'b0});
        end
    endtask

    task automatic test_split();
        logic [72:0] e3;
        logic [72:0] e5;
        ready = 1'b1;
        tick();
`ifdef TE_IRETIRE_SPLIT_EN
        e3 = {1'b1, 3'd0, 1'b1, 4'd12, 64'h100};
        e5 = {1'b1, 3'd3, 1'b1, 4'd8, 64'h118};
`else
        e3 = {1'b0, 3'd0, 1'b0, 4'd0, 64'h0};
        e5 = {1'b1, 3'd3, 1'b1, 4'd15, 64'h100};
`endif
        for (int c = 0; c < 3; c++) begin
            set_port(0, 3'd0, 64'h100 + 64'(c * 8), 1'b0);
            set_port(1, 3'd0, 64'h104 + 64'(c * 8), 1'b0);
            tick();
            clear_in();
        end
        total++;
        if (e3[72] ? (s_head !== e3) : (s_valid !== 1'b0)) begin
            bad++;
            $display("FAIL split_c3 got=%h exp=%h", s_head, e3);
        end
        set_port(0, 3'd0, 64'h118, 1'b0);
        set_port(1, 3'd0, 64'h11C, 1'b0);
        tick();
        clear_in();
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL split_c4 got=%b exp=0", s_valid);
        end
        set_port(0, 3'd0, 64'h120, 1'b0);
        set_port(1, 3'd3, 64'h124, 1'b0);
        tick();
        clear_in();
        total++;
        if (s_head !== e5) begin
            bad++;
            $display("FAIL split_c5 got=%h exp=%h", s_head, e5);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_special_trap();
        test_interrupt();
        test_overflow();
        test_mid_reset();
        test_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
